// File: rtl/led_btn_axil_slave.sv
// AXI4-Lite slave with an LED control register, a synchronized button
// status register, W1C button rising-edge event latches and a level IRQ.
// Optional button debouncer: define LED_BTN_DEBOUNCE_EN to enable it.
module led_btn_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int LED_WIDTH          = 4,
   parameter int BTN_WIDTH          = 4,
   parameter int DEBOUNCE_CYCLES    = 16
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [LED_WIDTH-1:0]            LED,
   input  logic [BTN_WIDTH-1:0]            BTN,
   output logic                            IRQ
);
   localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t w_state_reg, w_state_next;
   r_state_t r_state_reg, r_state_next;

   // Held low through the first cycle after reset so no handshake starts there
   logic init_done_reg;
   logic wr_fire, rd_fire;

   logic [C_S_AXI_DATA_WIDTH-1:0] strb_mask, wdata_masked, rd_mux, rdata_reg;
   logic [LED_WIDTH-1:0]          led_reg, led_next;
   logic [BTN_WIDTH-1:0]          irq_en_reg, irq_en_next;
   logic [BTN_WIDTH-1:0]          evt_reg, evt_next, evt_clr, evt_rise;
   logic [BTN_WIDTH-1:0]          sync1_reg, stat_reg, stat_next;
   logic                          irq_reg;

   genvar gi;

   // Byte-lane mask from WSTRB
   generate
      for (gi = 0; gi < STRB_W; gi++) begin : g_strb
         assign strb_mask[gi*8 +: 8] = {8{S_AXI_WSTRB[gi]}};
      end
   endgenerate

   assign wdata_masked = S_AXI_WDATA & strb_mask;

   // ---------------- write FSM ----------------
   // Write state register
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) w_state_reg <= W_IDLE;
      else              w_state_reg <= w_state_next;
   end

   // Write next state: accept only when address and data arrive together
   always_comb begin
      w_state_next = w_state_reg;
      case (w_state_reg)
         W_IDLE:  if (wr_fire) w_state_next = W_RESP;
         W_RESP:  if (S_AXI_BREADY) w_state_next = W_IDLE;
         default: w_state_next = W_IDLE;
      endcase
   end

   // Write channel outputs
   always_comb begin
      S_AXI_AWREADY = (w_state_reg == W_IDLE) && init_done_reg && S_AXI_AWVALID && S_AXI_WVALID;
      S_AXI_WREADY  = S_AXI_AWREADY;
      S_AXI_BVALID  = (w_state_reg == W_RESP);
      S_AXI_BRESP   = 2'b00;
   end

   assign wr_fire = S_AXI_AWREADY;

   // ---------------- read FSM ----------------
   // Read state register
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) r_state_reg <= R_IDLE;
      else              r_state_reg <= r_state_next;
   end

   // Read next state
   always_comb begin
      r_state_next = r_state_reg;
      case (r_state_reg)
         R_IDLE:  if (rd_fire) r_state_next = R_DATA;
         R_DATA:  if (S_AXI_RREADY) r_state_next = R_IDLE;
         default: r_state_next = R_IDLE;
      endcase
   end

   // Read channel outputs
   always_comb begin
      S_AXI_ARREADY = (r_state_reg == R_IDLE) && init_done_reg && S_AXI_ARVALID;
      S_AXI_RVALID  = (r_state_reg == R_DATA);
      S_AXI_RRESP   = 2'b00;
      S_AXI_RDATA   = rdata_reg;
   end

   assign rd_fire = S_AXI_ARREADY;

   // Read mux over current register values; upper bits read as zero
   always_comb begin
      rd_mux = '0;
      case (S_AXI_ARADDR[3:2])
         2'd0:    rd_mux[LED_WIDTH-1:0] = led_reg;
         2'd1:    rd_mux[BTN_WIDTH-1:0] = stat_reg;
         2'd2:    rd_mux[BTN_WIDTH-1:0] = evt_reg;
         default: rd_mux[BTN_WIDTH-1:0] = irq_en_reg;
      endcase
   end

   // Register write decode with byte-lane merging; BTN_STAT writes are dropped
   always_comb begin
      led_next    = led_reg;
      irq_en_next = irq_en_reg;
      evt_clr     = '0;
      if (wr_fire) begin
         case (S_AXI_AWADDR[3:2])
            2'd0:    led_next = wdata_masked[LED_WIDTH-1:0] | (led_reg & ~strb_mask[LED_WIDTH-1:0]);
            2'd2:    evt_clr = wdata_masked[BTN_WIDTH-1:0];
            2'd3:    irq_en_next = wdata_masked[BTN_WIDTH-1:0] | (irq_en_reg & ~strb_mask[BTN_WIDTH-1:0]);
            default: ;
         endcase
      end
   end

   // A new rising edge beats a simultaneous W1C clear
   assign evt_rise = stat_next & ~stat_reg;
   assign evt_next = (evt_reg & ~evt_clr) | evt_rise;

   // Register file, synchronizer front stage, IRQ and read data
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         init_done_reg <= 1'b0;
         led_reg       <= '0;
         irq_en_reg    <= '0;
         evt_reg       <= '0;
         sync1_reg     <= '0;
         stat_reg      <= '0;
         irq_reg       <= 1'b0;
         rdata_reg     <= '0;
      end else begin
         init_done_reg <= 1'b1;
         led_reg       <= led_next;
         irq_en_reg    <= irq_en_next;
         evt_reg       <= evt_next;
         sync1_reg     <= BTN;
         stat_reg      <= stat_next;
         irq_reg       <= |(evt_reg & irq_en_reg);
         if (rd_fire) rdata_reg <= rd_mux;
      end
   end

`ifdef LED_BTN_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [BTN_WIDTH-1:0] sync2_reg;
   logic [CNT_W-1:0]     cnt_reg  [BTN_WIDTH];
   logic [CNT_W-1:0]     cnt_next [BTN_WIDTH];

   // Per-bit stability counter; any return to equality restarts it
   always_comb begin
      stat_next = stat_reg;
      for (int i = 0; i < BTN_WIDTH; i++) begin
         cnt_next[i] = '0;
         if (sync2_reg[i] != stat_reg[i]) begin
            if (cnt_reg[i] == CNT_LAST) stat_next[i] = sync2_reg[i];
            else                        cnt_next[i] = cnt_reg[i] + 1'b1;
         end
      end
   end

   // Second synchronizer stage and debounce counters
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         sync2_reg <= '0;
         for (int i = 0; i < BTN_WIDTH; i++) cnt_reg[i] <= '0;
      end else begin
         sync2_reg <= sync1_reg;
         for (int i = 0; i < BTN_WIDTH; i++) cnt_reg[i] <= cnt_next[i];
      end
   end
`else
   // stat_reg itself is the second synchronizer stage
   assign stat_next = sync1_reg;

   logic unused_cfg;
   assign unused_cfg = (DEBOUNCE_CYCLES > 0);
`endif

   assign LED = led_reg;
   assign IRQ = irq_reg;

   logic unused_inputs;
   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                            wdata_masked, strb_mask};
endmodule

// File: tb/tb_led_btn_axil_slave.sv
// Self-checking bench for led_btn_axil_slave: directed protocol steps plus a
// randomized register/button phase checked against a behavioural model.
module tb_led_btn_axil_slave;
   localparam int DBC = 16;
`ifdef LED_BTN_DEBOUNCE_EN
   localparam int LAT = 2 + DBC;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic [3:0]  led, btn;
   logic        irq;

   int passes = 0;
   int fails  = 0;
   int total  = 0;

   // Behavioural model state
   logic [31:0] m_led, m_stat, m_evt, m_en;

   led_btn_axil_slave #(
      .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4),
      .LED_WIDTH(4), .BTN_WIDTH(4), .DEBOUNCE_CYCLES(DBC)
   ) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .LED(led), .BTN(btn), .IRQ(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] byte_mask(input logic [3:0] s);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
      return m;
   endfunction

   task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] m;
      m = byte_mask(s);
      case (a[3:2])
         2'd0:    m_led = ((d & m) | (m_led & ~m)) & 32'hF;
         2'd2:    m_evt = m_evt & ~(d & m);
         2'd3:    m_en  = ((d & m) | (m_en & ~m)) & 32'hF;
         default: ;
      endcase
   endtask

   function automatic logic [31:0] model_read(input logic [3:0] a);
      case (a[3:2])
         2'd0:    return m_led;
         2'd1:    return m_stat;
         2'd2:    return m_evt;
         default: return m_en;
      endcase
   endfunction

   function automatic logic [31:0] model_irq();
      return {31'b0, |(m_evt & m_en)};
   endfunction

   // Handshake a write; returns just after the commit edge with BVALID pending
   task automatic wr_start(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      @(posedge clk); #1;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!(awready && wready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wr_accept", {31'b0, awready && wready}, 32'd1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      model_write(a, d, s);
      check("led_after_wr", {28'b0, led}, m_led);
      $display("write addr=%h data=%08h strb=%h", a, d, s);
   endtask

   task automatic wr_finish();
      bready = 1'b1;
      @(negedge clk);
      check("bvalid", {31'b0, bvalid}, 32'd1);
      check("bresp", {30'b0, bresp}, 32'd0);
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      wr_start(a, d, s);
      wr_finish();
   endtask

   task automatic rd_start(input logic [3:0] a);
      int n;
      @(posedge clk); #1;
      araddr = a; arvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!arready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rd_accept", {31'b0, arready}, 32'd1);
      @(posedge clk); #1;
      arvalid = 1'b0;
   endtask

   task automatic rd_finish(output logic [31:0] d);
      rready = 1'b1;
      @(negedge clk);
      check("rvalid", {31'b0, rvalid}, 32'd1);
      check("rresp", {30'b0, rresp}, 32'd0);
      d = rdata;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   task automatic axi_read_check(input logic [3:0] a, input string tag);
      logic [31:0] d;
      logic [31:0] e;
      e = model_read(a);
      rd_start(a);
      rd_finish(d);
      check(tag, d, e);
      $display("read  addr=%h data=%08h expect=%08h", a, d, e);
   endtask

   // Change the buttons and wait until the filtered level and IRQ have settled
   task automatic btn_set(input logic [3:0] v);
      @(posedge clk); #1;
      btn = v;
      m_evt  = m_evt | ({28'b0, v} & ~m_stat);
      m_stat = {28'b0, v};
      repeat (LAT + 2) @(posedge clk);
      #1;
      $display("btn   level=%h", v);
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] old_led;
      int op;

      m_led = '0; m_stat = '0; m_evt = '0; m_en = '0;
      rst = 1'b1; btn = '0; awprot = '0; arprot = '0;
      bready = 1'b0; rready = 1'b0;
      // Valids already high while reset is released: readies must wait a cycle
      awaddr = 4'h0; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 4'h0; arvalid = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_awready", {31'b0, awready}, 32'd0);
      check("rst_wready", {31'b0, wready}, 32'd0);
      check("rst_arready", {31'b0, arready}, 32'd0);
      check("rst_led", {28'b0, led}, 32'd0);
      check("rst_irq", {31'b0, irq}, 32'd0);
      check("rst_bvalid", {31'b0, bvalid}, 32'd0);
      check("rst_rvalid", {31'b0, rvalid}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;

      // Basic LED write and readback
      axi_write(4'h0, 32'h0000_0005, 4'hF);
      axi_read_check(4'h0, "led_rd");

      // Byte-gated IRQ_EN write, write to read-only status
      axi_write(4'hC, 32'hFFFF_FFFF, 4'h1);
      axi_read_check(4'hC, "irqen_rd");
      axi_write(4'h4, 32'h0000_000A, 4'hF);
      axi_read_check(4'h4, "stat_ro_rd");

      // Button rise -> event -> IRQ with exact latency, then W1C
      axi_write(4'hC, 32'h2, 4'hF);
      @(posedge clk); #1;
      btn = 4'h2;
      m_evt = m_evt | 32'h2; m_stat = 32'h2;
      repeat (LAT) @(posedge clk);
      #1 check("irq_before", {31'b0, irq}, 32'd0);
      @(posedge clk);
      #1 check("irq_set", {31'b0, irq}, 32'd1);
      axi_read_check(4'h4, "stat_btn");
      axi_read_check(4'h8, "evt_btn");
      wr_start(4'h8, 32'h2, 4'hF);
      check("irq_lag", {31'b0, irq}, 32'd1);
      wr_finish();
      check("irq_clr", {31'b0, irq}, 32'd0);
      axi_read_check(4'h8, "evt_clr");

`ifdef LED_BTN_DEBOUNCE_EN
      // Glitch one cycle shorter than the debounce window
      @(posedge clk); #1;
      btn = 4'h3;
      repeat (DBC - 1) @(posedge clk);
      #1 btn = 4'h2;
      repeat (DBC + 4) @(posedge clk);
      axi_read_check(4'h4, "glitch_stat");
      axi_read_check(4'h8, "glitch_evt");
`endif

      // Simultaneous read and write of LED: read returns pre-write value
      old_led = m_led;
      @(posedge clk); #1;
      awaddr = 4'h0; wdata = 32'h0000_000E; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 4'h0; arvalid = 1'b1;
      @(negedge clk);
      check("same_awready", {31'b0, awready}, 32'd1);
      check("same_arready", {31'b0, arready}, 32'd1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      model_write(4'h0, 32'h0000_000E, 4'hF);
      rd_finish(d);
      check("same_rd_old", d, old_led);
      wr_finish();
      check("same_led_new", {28'b0, led}, m_led);

      // Back-pressure on B blocks a queued second write
      wr_start(4'h0, 32'h3, 4'hF);
      awaddr = 4'h0; wdata = 32'hC; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_bvalid", {31'b0, bvalid}, 32'd1);
         check("bp_awready", {31'b0, awready || wready}, 32'd0);
         @(posedge clk); #1;
      end
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      @(negedge clk);
      check("bp_second_acc", {31'b0, awready && wready}, 32'd1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      model_write(4'h0, 32'hC, 4'hF);
      check("bp_second_led", {28'b0, led}, m_led);
      wr_finish();

      // Back-pressure on R keeps RDATA stable
      rd_start(4'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rp_rvalid", {31'b0, rvalid}, 32'd1);
         check("rp_rdata", rdata, m_led);
         @(posedge clk); #1;
      end
      rd_finish(d);
      check("rp_final", d, m_led);

      // Randomized register and button activity
      for (int it = 0; it < 12; it++) begin
         op = $urandom_range(0, 3);
         case (op)
            0:       axi_write(4'h0, $urandom, 4'($urandom_range(0, 15)));
            1:       axi_write(4'hC, $urandom, 4'($urandom_range(0, 15)));
            2:       btn_set(4'($urandom_range(0, 15)));
            default: axi_write(4'h8, $urandom, 4'($urandom_range(0, 15)));
         endcase
         for (int a = 0; a < 4; a++) axi_read_check(4'(a * 4), "rand_rd");
         check("rand_irq", {31'b0, irq}, model_irq());
      end

      // Reset in the middle of pending B and R responses
      axi_write(4'hC, 32'hF, 4'hF);
      btn_set(4'h0);
      btn_set(4'h1);
      check("pre_rst_irq", {31'b0, irq}, 32'd1);
      wr_start(4'h0, 32'h5, 4'hF);
      rd_start(4'hC);
      rst = 1'b1; btn = 4'h0;
      @(posedge clk); #1;
      rst = 1'b0;
      m_led = '0; m_stat = '0; m_evt = '0; m_en = '0;
      check("abort_bvalid", {31'b0, bvalid}, 32'd0);
      check("abort_rvalid", {31'b0, rvalid}, 32'd0);
      check("abort_led", {28'b0, led}, 32'd0);
      check("abort_irq", {31'b0, irq}, 32'd0);
      check("abort_rdata", rdata, 32'd0);
      repeat (LAT + 2) @(posedge clk);
      for (int a = 0; a < 4; a++) axi_read_check(4'(a * 4), "post_rst_rd");

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
